// File: rtl/divider_arbiter_pkg.sv
// Shared types and constants for the two-requester divider arbiter.
package divider_arbiter_pkg;

  localparam int unsigned WIDTH      = 8;
  localparam int unsigned CNT_W      = 4;
  localparam int unsigned SETTLE_MAX = 15;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RESP   = 2'd2
  } state_e;

  typedef struct packed {
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             div0;
  } div_res_t;

  // A zero divisor overrides whatever the array produced: Q saturates, R echoes the dividend.
  function automatic div_res_t div_result(input logic [WIDTH-1:0] a,
                                          input logic [WIDTH-1:0] b,
                                          input logic [WIDTH-1:0] q,
                                          input logic [WIDTH-1:0] r);
    div_res_t res;
    res.div0 = (b == '0);
    res.q    = res.div0 ? {WIDTH{1'b1}} : q;
    res.r    = res.div0 ? a : r;
    return res;
  endfunction

endpackage

// File: rtl/divider_arbiter_rr_arb2.sv
// Two-input round-robin grant; the previous winner is held by the parent.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] gnt,
  output logic       gnt_id
);

  always_comb begin
    gnt_id = 1'b0;
    gnt    = 2'b00;
    unique case (valid)
      2'b01:   gnt_id = 1'b0;
      2'b10:   gnt_id = 1'b1;
      2'b11:   gnt_id = ~last_grant;
      default: gnt_id = 1'b0;
    endcase
    if (|valid) begin
      gnt = gnt_id ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/divider_arbiter.sv
// Shares one combinational array divider between two requesters, holding its
// inputs for a fixed settle time before registering the result.
module divider_arbiter
  import divider_arbiter_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic [WIDTH-1:0] div_a,
  output logic [WIDTH-1:0] div_b,
  input  logic [WIDTH-1:0] div_q,
  input  logic [WIDTH-1:0] div_r,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_q,
  output logic [WIDTH-1:0] resp_r,
  output logic             resp_div0
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  state_e           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             id_q, id_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] div_a_q, div_a_d;
  logic [WIDTH-1:0] div_b_q, div_b_d;
  div_res_t         res_q, res_d;
  logic             resp_valid_q, resp_valid_d;
  logic             resp_id_q, resp_id_d;

  logic [1:0] gnt;
  logic       gnt_id;

  rr_arb2 u_arb (
    .valid      ({req1_valid, req0_valid}),
    .last_grant (last_grant_q),
    .gnt        (gnt),
    .gnt_id     (gnt_id)
  );

  // Next-state: accept in IDLE, count down in SETTLE, hold until drained in RESP.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    cnt_d        = cnt_q;
    div_a_d      = div_a_q;
    div_b_d      = div_b_q;
    res_d        = res_q;
    resp_valid_d = resp_valid_q;
    resp_id_d    = resp_id_q;

    unique case (state_q)
      IDLE: begin
        if (|gnt) begin
          div_a_d      = gnt_id ? req1_a : req0_a;
          div_b_d      = gnt_id ? req1_b : req0_b;
          id_d         = gnt_id;
          last_grant_d = gnt_id;
          cnt_d        = CNT_LOAD;
          state_d      = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          res_d        = div_result(div_a_q, div_b_q, div_q, div_r);
          resp_id_d    = id_q;
          resp_valid_d = 1'b1;
          state_d      = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      cnt_q        <= '0;
      div_a_q      <= '0;
      div_b_q      <= '0;
      res_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      cnt_q        <= cnt_d;
      div_a_q      <= div_a_d;
      div_b_q      <= div_b_d;
      res_q        <= res_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
    end
  end

  // Ready mirrors the live grant so a requester sees acceptance in the same cycle.
  assign req0_ready = rst_n & (state_q == IDLE) & gnt[0];
  assign req1_ready = rst_n & (state_q == IDLE) & gnt[1];

  assign div_a      = div_a_q;
  assign div_b      = div_b_q;
  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_q     = res_q.q;
  assign resp_r     = res_q.r;
  assign resp_div0  = res_q.div0;

endmodule
